// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state numbering (common with uart_tx),
// default frame/baud constants and a 3-input majority helper.
package uart_pkg;

   localparam int DEFAULT_DATA_LEN     = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 87;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BIT  = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Bus-side output bundle of the UART receiver: received word, its strobe,
// the busy flag and the framing-error strobe.
interface uart_rx_if #(
   parameter int DATA_LEN = uart_pkg::DEFAULT_DATA_LEN
) ();

   logic [DATA_LEN-1:0] rx_data;
   logic                rx_valid;
   logic                rx_busy;
   logic                rx_frame_err;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_busy,
      output rx_frame_err
   );

   modport slave (
      input rx_data,
      input rx_valid,
      input rx_busy,
      input rx_frame_err
   );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; RESET_VAL sets the
// value both stages take on reset (e.g. 1 for an idle-high serial line).
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_reg <= RESET_VAL;
         sync_reg <= RESET_VAL;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (start, DATA_LEN data bits LSB first, stop; no parity), sampling mid-bit.
// Optional: define UART_RX_MAJORITY_EN to vote each sample over the last three rx_s values.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_LEN     = DEFAULT_DATA_LEN,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      rx_serial,
   uart_rx_if.master bus
);

   localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LEN - 1);

   logic rx_s;
   logic sample_bit;

   uart_state_t         state_reg,     state_next;
   logic [CNT_W-1:0]    clk_count_reg, clk_count_next;
   logic [BIT_W-1:0]    bit_count_reg, bit_count_next;
   logic [DATA_LEN-1:0] shift_reg,     shift_next;
   logic [DATA_LEN-1:0] rx_data_reg,   rx_data_next;
   logic                rx_valid_reg,  rx_valid_next;
   logic                rx_busy_reg,   rx_busy_next;
   logic                frame_err_reg, frame_err_next;

   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_serial),
      .q     (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // Two previous rx_s values; together with rx_s they outvote a one-cycle glitch.
   logic [1:0] hist_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_reg <= 2'b11;
      end else begin
         hist_reg <= {hist_reg[0], rx_s};
      end
   end

   assign sample_bit = maj3(rx_s, hist_reg[0], hist_reg[1]);
`else
   assign sample_bit = rx_s;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         clk_count_reg <= '0;
         bit_count_reg <= '0;
         shift_reg     <= '0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         rx_busy_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         clk_count_reg <= clk_count_next;
         bit_count_reg <= bit_count_next;
         shift_reg     <= shift_next;
         rx_data_reg   <= rx_data_next;
         rx_valid_reg  <= rx_valid_next;
         rx_busy_reg   <= rx_busy_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      clk_count_next = clk_count_reg;
      bit_count_next = bit_count_reg;
      shift_next     = shift_reg;
      rx_data_next   = rx_data_reg;
      rx_valid_next  = 1'b0;
      rx_busy_next   = rx_busy_reg;
      frame_err_next = 1'b0;

      case (state_reg)
         IDLE: begin
            // Edge detection uses the raw synchronized line; only sample points vote.
            if (!rx_s) begin
               state_next     = START_BIT;
               clk_count_next = '0;
               rx_busy_next   = 1'b1;
            end
         end

         START_BIT: begin
            if (clk_count_reg == HALF_CNT) begin
               clk_count_next = '0;
               if (!sample_bit) begin
                  state_next     = DATA_BITS;
                  bit_count_next = '0;
               end else begin
                  state_next   = IDLE;
                  rx_busy_next = 1'b0;
               end
            end else begin
               clk_count_next = clk_count_reg + CNT_W'(1);
            end
         end

         DATA_BITS: begin
            if (clk_count_reg == LAST_CNT) begin
               clk_count_next            = '0;
               shift_next[bit_count_reg] = sample_bit;
               if (bit_count_reg == LAST_BIT) begin
                  state_next = STOP_BIT;
               end else begin
                  bit_count_next = bit_count_reg + BIT_W'(1);
               end
            end else begin
               clk_count_next = clk_count_reg + CNT_W'(1);
            end
         end

         STOP_BIT: begin
            if (clk_count_reg == LAST_CNT) begin
               clk_count_next = '0;
               rx_busy_next   = 1'b0;
               if (sample_bit) begin
                  rx_data_next  = shift_reg;
                  rx_valid_next = 1'b1;
                  state_next    = IDLE;
               end else begin
                  frame_err_next = 1'b1;
                  state_next     = WAIT_HIGH;
               end
            end else begin
               clk_count_next = clk_count_reg + CNT_W'(1);
            end
         end

         WAIT_HIGH: begin
            // A held-low (break) line must return high before a new start is accepted.
            if (rx_s) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next     = IDLE;
            clk_count_next = '0;
            bit_count_next = '0;
            rx_busy_next   = 1'b0;
         end
      endcase
   end

   assign bus.rx_data      = rx_data_reg;
   assign bus.rx_valid     = rx_valid_reg;
   assign bus.rx_busy      = rx_busy_reg;
   assign bus.rx_frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16 (HALF=7).
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int DL   = 8;
   localparam int HALF = (CPB - 1) / 2;
   localparam int LAT  = HALF + (DL + 1) * CPB + 3;

   logic clk = 1'b0;
   logic reset;
   logic rx_serial;

   int checks = 0;
   int errors = 0;

   int cycle_cnt = 0;
   int valid_tot = 0;
   int err_tot   = 0;
   int busy_tot  = 0;
   int both_tot  = 0;
   int valid_cyc = 0;
   logic [DL-1:0] vlog [0:63];

   uart_rx_if #(.DATA_LEN(DL)) rx_bus ();

   uart_rx #(
      .DATA_LEN     (DL),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_serial (rx_serial),
      .bus       (rx_bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   always @(negedge clk) begin
      if (rx_bus.rx_valid === 1'b1) begin
         vlog[valid_tot] <= rx_bus.rx_data;
         valid_tot       <= valid_tot + 1;
         valid_cyc       <= cycle_cnt;
      end
      if (rx_bus.rx_frame_err === 1'b1) err_tot <= err_tot + 1;
      if (rx_bus.rx_busy === 1'b1) busy_tot <= busy_tot + 1;
      if (rx_bus.rx_valid === 1'b1 && rx_bus.rx_frame_err === 1'b1) both_tot <= both_tot + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      rx_serial = 1'b0;
      tick(CPB);
      for (int i = 0; i < DL; i++) begin
         rx_serial = d[i];
         tick(CPB);
      end
      rx_serial = stop;
      tick(CPB);
   endtask

   initial begin
      int v0, e0, b0, start_cyc, lat;
      logic [7:0] d;
      logic [7:0] glitch_exp;

      // Reset state
      reset     = 1'b1;
      rx_serial = 1'b1;
      tick(3);
      check("reset_rx_data", 32'(rx_bus.rx_data), 32'h0);
      check("reset_rx_valid", 32'(rx_bus.rx_valid), 32'h0);
      check("reset_rx_busy", 32'(rx_bus.rx_busy), 32'h0);
      check("reset_rx_frame_err", 32'(rx_bus.rx_frame_err), 32'h0);
      reset = 1'b0;
      tick(5);

      // Single frame 0xA5
      v0 = valid_tot; e0 = err_tot; b0 = busy_tot;
      start_cyc = cycle_cnt;
      send_frame(8'hA5, 1'b1);
      tick(4);
      lat = valid_cyc - start_cyc;
      check("a5_valid_count", 32'(valid_tot - v0), 32'd1);
      check("a5_data_log", 32'(vlog[v0]), 32'hA5);
      check("a5_rx_data", 32'(rx_bus.rx_data), 32'hA5);
      check("a5_no_frame_err", 32'(err_tot - e0), 32'd0);
      check("a5_busy_seen", 32'(busy_tot > b0), 32'd1);
      check("a5_busy_low_after", 32'(rx_bus.rx_busy), 32'd0);
      check("a5_latency_in_range", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);

      // Back-to-back frames, as a transmitter would send them
      v0 = valid_tot;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      tick(4);
      check("b2b_valid_count", 32'(valid_tot - v0), 32'd3);
      check("b2b_word0", 32'(vlog[v0]), 32'h00);
      check("b2b_word1", 32'(vlog[v0 + 1]), 32'hFF);
      check("b2b_word2", 32'(vlog[v0 + 2]), 32'h3C);

      // False start: 3-cycle low pulse
      v0 = valid_tot; e0 = err_tot; b0 = busy_tot;
      rx_serial = 1'b0;
      tick(3);
      rx_serial = 1'b1;
      tick(3 * CPB);
      check("false_busy_pulsed", 32'(busy_tot > b0), 32'd1);
      check("false_no_valid", 32'(valid_tot - v0), 32'd0);
      check("false_no_frame_err", 32'(err_tot - e0), 32'd0);
      check("false_busy_low", 32'(rx_bus.rx_busy), 32'd0);

      // Framing error followed by a held-low line, then a good frame
      v0 = valid_tot; e0 = err_tot;
      send_frame(8'h5A, 1'b0);
      b0 = busy_tot;
      rx_serial = 1'b0;
      tick(5 * CPB);
      check("ferr_one_pulse", 32'(err_tot - e0), 32'd1);
      check("ferr_no_valid", 32'(valid_tot - v0), 32'd0);
      check("ferr_data_kept", 32'(rx_bus.rx_data), 32'h3C);
      check("ferr_no_retrigger", 32'(busy_tot - b0), 32'd0);
      rx_serial = 1'b1;
      tick(2 * CPB);
      send_frame(8'h11, 1'b1);
      tick(4);
      check("ferr_next_valid", 32'(valid_tot - v0), 32'd1);
      check("ferr_next_data", 32'(rx_bus.rx_data), 32'h11);
      check("ferr_next_no_err", 32'(err_tot - e0), 32'd1);

      // Reset during data bit 4 of 0x77
      d = 8'h77;
      rx_serial = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_serial = d[i];
         tick(CPB);
      end
      rx_serial = d[4];
      tick(5);
      check("midrst_busy_before", 32'(rx_bus.rx_busy), 32'd1);
      reset     = 1'b1;
      rx_serial = 1'b1;
      #1;
      check("midrst_rx_data", 32'(rx_bus.rx_data), 32'h0);
      check("midrst_rx_valid", 32'(rx_bus.rx_valid), 32'h0);
      check("midrst_rx_busy", 32'(rx_bus.rx_busy), 32'h0);
      check("midrst_rx_frame_err", 32'(rx_bus.rx_frame_err), 32'h0);
      tick(2);
      reset = 1'b0;
      tick(2 * CPB);
      v0 = valid_tot;
      send_frame(8'h99, 1'b1);
      tick(4);
      check("midrst_next_valid", 32'(valid_tot - v0), 32'd1);
      check("midrst_next_data", 32'(rx_bus.rx_data), 32'h99);

      // One-cycle glitch at the sample point of data bit 2 of 0x00
`ifdef UART_RX_MAJORITY_EN
      glitch_exp = 8'h00;
`else
      glitch_exp = 8'h04;
`endif
      v0 = valid_tot; e0 = err_tot;
      rx_serial = 1'b0;
      tick(CPB);
      tick(2 * CPB);
      tick(1 + HALF);
      rx_serial = 1'b1;
      tick(1);
      rx_serial = 1'b0;
      tick(CPB - 2 - HALF);
      tick(5 * CPB);
      rx_serial = 1'b1;
      tick(CPB);
      tick(4);
      check("glitch_valid", 32'(valid_tot - v0), 32'd1);
      check("glitch_data", 32'(rx_bus.rx_data), 32'(glitch_exp));
      check("glitch_no_err", 32'(err_tot - e0), 32'd0);

      check("strobes_never_together", 32'(both_tot), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
